data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-organised data memory for the single-cycle RISC-V datapath. Sits behind the ALU address output and feeds the writeback mux.
- Synchronous write, combinational read gated by MemRead.
- Asynchronous active-low reset clears the whole array.

Parameters:
- Width, 32, data word width in bits (>= 8).
- Depth, 256, number of words; must equal 2^8 to match the Addr width.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- MemWrite  input  1  write enable, sampled on rising clk.
- MemRead  input  1  read enable, combinational gate on ReadData.
- Addr  input  8  word index 0..255 (word address, not byte address).
- WrData  input  Width  data to store.
- ReadData  output  Width  read data.

Behaviour:
- Storage: Depth entries of Width bits, indexed directly by Addr; no byte lanes, no alignment logic.
- Reset:
  - rst_n low clears every entry to 0 immediately, independent of clk.
  - While rst_n is low, ReadData = 0 and writes are ignored.
  - Deassertion is not synchronised internally; the first write can occur on the first rising clk with rst_n high.
- Write:
  - On rising clk with rst_n=1 and MemWrite=1, mem[Addr] <= WrData.
  - MemWrite=0 leaves contents unchanged.
  - No X-propagation guards are required; X on Addr with MemWrite=1 is a bench error.
- Read:
  - Combinational, zero-cycle latency.
  - ReadData = mem[Addr] when MemRead=1 and rst_n=1, else all zeros.
  - ReadData follows Addr, MemRead and array changes without waiting for clk.
- Simultaneous read and write to the same address:
  - Before the edge, ReadData shows the old contents.
  - After the edge (same cycle, post-update), ReadData shows WrData.
  - No bypass of WrData ahead of the edge.
- Reset mid-operation: rst_n falling while MemWrite=1 aborts any pending write. The entry reads 0 after reset regardless of clk phase.
- Address range: all 256 values are valid; there is no wrap or out-of-range case.
- MemRead and MemWrite are independent. Both may be high; neither blocks the other.
- No handshake and no ready/valid. Every access completes in the cycle it is presented.
- Contents persist indefinitely between writes. Only reset or a write modifies an entry.

Test Plan:
- Reset clear:
  - Write 0xDEADBEEF to Addr 0x10, pulse rst_n low for 3 ns between clock edges.
  - Required: ReadData at Addr 0x10 = 0 immediately, without waiting for a clk edge.
- Write/read same address:
  - MemRead=1, MemWrite=1, Addr=0x00, WrData=0xAAAAAAAA (alternating 10 pattern), after reset.
  - Required: ReadData=0x00000000 before the first rising edge, 0xAAAAAAAA after it, and stable thereafter.
- Read gating:
  - Address 0x00 holds 0xAAAAAAAA; drive MemRead=0.
  - Required: ReadData=0x00000000. Restoring MemRead=1 gives 0xAAAAAAAA combinationally.
- Address independence and bounds:
  - Write 0x11111111 to Addr 0x00 and 0x22222222 to Addr 0xFF on consecutive cycles, then MemWrite=0.
  - Required: Addr 0x00 reads 0x11111111, Addr 0xFF reads 0x22222222, Addr 0x7F reads 0.
- Write disable:
  - Address 0x05 holds 0x12345678; drive MemWrite=0 with WrData=0xFFFFFFFF for 4 cycles.
  - Required: Addr 0x05 still reads 0x12345678.
- Reset with pending write:
  - Assert rst_n=0 with MemWrite=1, Addr=0x20, WrData=0xCAFEF00D across a rising edge, then release.
  - Required: Addr 0x20 reads 0.

Source files
------------

// File: rtl/data_memory.sv
// data_memory
//   Word-organised data memory for the single-cycle RISC-V datapath. It sits
//   behind the ALU address output and feeds the writeback mux. Writes happen
//   on the rising clock edge. Reads are combinational and gated by MemRead.
//   An asynchronous active-low reset clears every entry.
//
// Ports
//   clk       in   1      system clock; writes on the rising edge
//   rst_n     in   1      asynchronous active-low reset; clears the whole array
//   MemWrite  in   1      write enable, sampled on the rising clk edge
//   MemRead   in   1      read enable, combinational gate on ReadData
//   Addr      in   8      word index 0..255 (word address, not byte address)
//   WrData    in   Width  data to store
//   ReadData  out  Width  mem[Addr] when MemRead && rst_n, else zero
module data_memory #(
  parameter int Width = 32,
  parameter int Depth = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic [7:0]       Addr,
  input  logic [Width-1:0] WrData,
  output logic [Width-1:0] ReadData
);

  logic [Width-1:0] mem_q [Depth];

  // The storage array. Reset is asynchronous, so a write that is pending
  // while rst_n falls is dropped, and the entry reads zero at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (MemWrite) begin
      mem_q[Addr] <= WrData;
    end
  end

  // The read path has no WrData bypass. A write to the address being read
  // shows up only after the clock edge that commits it.
  always_comb begin
    ReadData = '0;
    if (MemRead && rst_n) begin
      ReadData = mem_q[Addr];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         MemWrite;
  logic         MemRead;
  logic [7:0]   Addr;
  logic [W-1:0] WrData;
  logic [W-1:0] ReadData;

  int checks = 0;
  int errors = 0;

  // Expected read values are pushed when stimulus is applied and popped
  // when ReadData is sampled.
  logic [W-1:0] sb_q [$];
  logic [W-1:0] exp_v;

  // Reference contents used by the random test.
  logic [W-1:0] mem_m [256];

  data_memory #(.Width(W), .Depth(256)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .Addr     (Addr),
    .WrData   (WrData),
    .ReadData (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // One write, committed on the next rising edge. Inputs change on the
  // falling edge, and MemWrite is dropped on the following falling edge.
  task automatic do_write(input logic [7:0] a, input logic [W-1:0] d);
    @(negedge clk);
    MemWrite = 1'b1;
    Addr     = a;
    WrData   = d;
    @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Reset state: the array reads zero during reset and after release.
    MemRead = 1'b1;
    Addr    = 8'h10;
    #1;
    sb_q.push_back('0);
    exp_v = sb_q.pop_front();
    checks++;
    if (ReadData !== exp_v) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", ReadData, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_write(8'h10, 32'hDEADBEEF);
    Addr = 8'h10;
    #1;
    sb_q.push_back(32'hDEADBEEF);
    exp_v = sb_q.pop_front();
    checks++;
    if (ReadData !== exp_v) begin
      errors++;
      $display("FAIL reset_prewrite got=%h exp=%h", ReadData, exp_v);
    end
    // Pulse rst_n low for 3 ns between clock edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.push_back('0);
    exp_v = sb_q.pop_front();
    checks++;
    if (ReadData !== exp_v) begin
      errors++;
      $display("FAIL reset_immediate got=%h exp=%h", ReadData, exp_v);
    end
    #2;
    rst_n = 1'b1;
    #1;
    sb_q.push_back('0);
    exp_v = sb_q.pop_front();
    checks++;
    if (ReadData !== exp_v) begin
      errors++;
      $display("FAIL reset_cleared got=%h exp=%h", ReadData, exp_v);
    end
  endtask

  task automatic test_write_read_same();
    pulse_reset();
    @(negedge clk);
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    Addr     = 8'h00;
    WrData   = 32'hAAAAAAAA;
    #1;
    sb_q.push_back('0);
    exp_v = sb_q.pop_front();
    checks++;
    if (ReadData !== exp_v) begin
      errors++;
      $display("FAIL same_addr_pre_edge got=%h exp=%h", ReadData, exp_v);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      sb_q.push_back(32'hAAAAAAAA);
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData !== exp_v) begin
        errors++;
        $display("FAIL same_addr_post_edge%0d got=%h exp=%h", c, ReadData, exp_v);
      end
    end
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic test_read_gating();
    @(negedge clk);
    Addr    = 8'h00;
    MemRead = 1'b0;
    #1;
    sb_q.push_back('0);
    exp_v = sb_q.pop_front();
    checks++;
    if (ReadData !== exp_v) begin
      errors++;
      $display("FAIL gate_off got=%h exp=%h", ReadData, exp_v);
    end
    MemRead = 1'b1;
    #1;
    sb_q.push_back(32'hAAAAAAAA);
    exp_v = sb_q.pop_front();
    checks++;
    if (ReadData !== exp_v) begin
      errors++;
      $display("FAIL gate_on got=%h exp=%h", ReadData, exp_v);
    end
  endtask

  task automatic test_bounds();
    logic [7:0]   addrs [3];
    logic [W-1:0] exps  [3];
    addrs = '{8'h00, 8'hFF, 8'h7F};
    exps  = '{32'h11111111, 32'h22222222, 32'h00000000};
    // Two writes on consecutive rising edges.
    @(negedge clk);
    MemWrite = 1'b1;
    Addr     = 8'h00;
    WrData   = 32'h11111111;
    @(negedge clk);
    Addr     = 8'hFF;
    WrData   = 32'h22222222;
    @(negedge clk);
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Addr = addrs[i];
      sb_q.push_back(exps[i]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData !== exp_v) begin
        errors++;
        $display("FAIL bounds addr=%h got=%h exp=%h", addrs[i], ReadData, exp_v);
      end
    end
  endtask

  task automatic test_write_disable();
    do_write(8'h05, 32'h12345678);
    @(negedge clk);
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    Addr     = 8'h05;
    WrData   = 32'hFFFFFFFF;
    for (int c = 0; c < 4; c++) begin
      sb_q.push_back(32'h12345678);
      @(posedge clk);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData !== exp_v) begin
        errors++;
        $display("FAIL write_disable cyc=%0d got=%h exp=%h", c, ReadData, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]   a;
    logic [W-1:0] d;
    logic         rd;
    pulse_reset();
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      a  = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      d  = $urandom;
      rd = ($urandom_range(0, 3) != 0);
      Addr    = a;
      MemRead = rd;
      if ($urandom_range(0, 1) == 1) begin
        MemWrite = 1'b1;
        WrData   = d;
        // Pre-edge sees the old contents; post-edge sees the new word.
        sb_q.push_back(rd ? mem_m[a] : '0);
        mem_m[a] = d;
        sb_q.push_back(rd ? d : '0);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (ReadData !== exp_v) begin
          errors++;
          $display("FAIL rand_pre n=%0d addr=%h got=%h exp=%h", n, a, ReadData, exp_v);
        end
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (ReadData !== exp_v) begin
          errors++;
          $display("FAIL rand_post n=%0d addr=%h got=%h exp=%h", n, a, ReadData, exp_v);
        end
      end else begin
        MemWrite = 1'b0;
        WrData   = d;
        sb_q.push_back(rd ? mem_m[a] : '0);
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (ReadData !== exp_v) begin
          errors++;
          $display("FAIL rand_read n=%0d addr=%h got=%h exp=%h", n, a, ReadData, exp_v);
        end
      end
    end
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic test_reset_pending_write();
    logic [7:0]   addrs [3];
    logic [W-1:0] before_v;
    addrs = '{8'h20, 8'h05, 8'hFF};
    do_write(8'h05, 32'h0BADC0DE);
    do_write(8'hFF, 32'h55AA55AA);
    @(negedge clk);
    MemRead = 1'b1;
    Addr    = 8'hFF;
    #1;
    before_v = ReadData;
    checks++;
    if (before_v !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL pending_prefill got=%h exp=%h", before_v, 32'h55AA55AA);
    end
    MemWrite = 1'b1;
    Addr     = 8'h20;
    WrData   = 32'hCAFEF00D;
    rst_n    = 1'b0;
    @(posedge clk);
    #2;
    @(negedge clk);
    MemWrite = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Addr = addrs[i];
      sb_q.push_back('0);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData !== exp_v) begin
        errors++;
        $display("FAIL pending_reset addr=%h got=%h exp=%h", addrs[i], ReadData, exp_v);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    Addr     = '0;
    WrData   = '0;
    test_reset();
    test_write_read_same();
    test_read_gating();
    test_bounds();
    test_write_disable();
    test_random();
    test_reset_pending_write();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
